qoi_decode_accel: RTL and testbench
===================================

Name: qoi_decode_accel

Overview:
- Memory-mapped QOI image-decode accelerator on the 65C02 system bus.
- The CPU feeds QOI chunk bytes one at a time through a register window.
- The block decodes them into RGBA pixels and writes the pixels into an internal 1 KB output buffer.
- The CPU reads the decoded pixels back through a separate memory window. Both windows are selected by external address decode.

Parameters:
- None. Buffer depth is fixed at 256 pixels × 4 bytes.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  register window select; register is addr[2:0].
- mem_cs  in  1  output-buffer window select; byte address is addr[9:0].
- we  in  1  bus write strobe, qualified by cs or mem_cs.
- data_i  in  8  CPU write data.
- data_o  out  8  CPU read data.
- addr  in  10  bus address, low bits.

Behaviour:
- Register map, addr[2:0]:
  - 0 CTRL, write only. bit0=1 resets the decoder: prev pixel := (0,0,0,255), index table all zero, state IDLE, run cleared. bit1=1 clears the pixel pointer. Reads return 0.
  - 1 STATUS, read only. bit0 busy (run emitting or pixel pending). bit1 opcode expected (state IDLE). bit2 pointer wrapped (sticky). bit3 overrun (see Optional Feature). Other bits 0.
  - 2 DATA_IN, write only. Accepts the next QOI stream byte.
  - 3 PTR, read only. Pixel pointer, 8 bits.
  - 4 RUN_LEFT, read only. Pixels still to emit in the current run.
  - 5 PREV_R, 6 PREV_G, 7 PREV_B, read only. Current previous pixel.
- Register reads are combinational: data_o is valid in the same cycle as cs.
- Buffer reads are registered: data_o is valid the cycle after mem_cs.
- data_o selection: if the previous cycle was a buffer read, output the registered buffer byte; otherwise output the register mux.
- Buffer writes: mem_cs&we writes data_i. Pixel writes from the decoder win on a same-cycle collision at the same byte.
- Buffer layout: pixel p occupies bytes 4p..4p+3 in order R,G,B,A. Implement as 4 byte lanes; addr[1:0] selects the lane.
- Decoder states:
  - IDLE. Byte 0xFE goes to RGB (3 more bytes); 0xFF goes to RGBA (4 more bytes).
  - 00iiiiii INDEX: pixel := index[i].
  - 01rrggbb DIFF: each channel += field−2, mod 256.
  - 10gggggg goes to LUMA2 to collect the second byte. dg=field−32. Second byte drdg[7:4]−8 and dbdg[3:0]−8 give dr=dg+drdg and db=dg+dbdg. Alpha is unchanged.
  - 11rrrrrr RUN: emit the previous pixel rrrrrr+1 times, 1 to 62.
- A pixel is emitted 1 cycle after the completing byte write.
- Each emission, in one cycle:
  - write 4 bytes at PTR*4;
  - prev := pixel;
  - index[(r*3+g*5+b*7+a*11)%64] := pixel;
  - PTR += 1, wrapping at 256 and setting the STATUS wrapped bit.
- RUN emits one pixel per cycle with busy=1. RUN_LEFT decrements each cycle.
- DATA_IN writes while busy=1 are dropped.
- CTRL bit0 written mid-run or mid-chunk aborts immediately; no further pixels are written.
- Reset values:
  - data_o=0, PTR=0, state IDLE, prev=(0,0,0,255), index all 0, STATUS=0x02.
  - Buffer contents are undefined.

Optional Feature:
- Macro QOI_OVERRUN_EN.
- With the macro defined: a DATA_IN write while busy sets STATUS bit3 (sticky). Any CTRL write clears it.
- Without the macro: the write is dropped silently and bit3 reads 0.

Test Plan:
- Reset:
  - Release reset, then read STATUS, PTR and PREV.
  - Expect 0x02, 0x00 and (0,0,0).
  - Expect PREV_R/G/B to read 0x00.
- RGB then INDEX:
  - Write DATA_IN 0xFE,0x10,0x20,0x30, then 0x15 (hash 21).
  - Expect buffer bytes 0..7 = 10 20 30 FF 10 20 30 FF and PTR=2.
- DIFF and LUMA:
  - After the above, write 0x7F, then 0xA1,0x88.
  - Expect pixel2=(11,21,31,FF), pixel3=(12,22,32,FF) and PTR=4.
- RUN:
  - After the above, write 0xC2.
  - Expect busy=1 for 3 cycles, pixels 4..6 = (12,22,32,FF) and PTR=7.
- Overrun (QOI_OVERRUN_EN defined):
  - Write 0xFD (run of 62), then immediately write DATA_IN again.
  - Expect STATUS bit3=1, the byte ignored, and PTR advanced by exactly 62.
  - Write CTRL=0x01 and expect bit3=0.
- Wrap and abort:
  - Emit 256 pixels via runs and expect PTR=0 and STATUS bit2=1.
  - Start a run of 62, then write CTRL=0x03 mid-run.
  - Expect PTR=0, RUN_LEFT=0 and no further buffer writes.

Source files
------------

// File: rtl/qoi_decode_accel.sv
// qoi_decode_accel: QOI chunk decoder feeding a 256-pixel RGBA buffer.
// Define QOI_OVERRUN_EN to flag DATA_IN writes dropped while busy.
module qoi_decode_accel (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       mem_cs,
  input  logic       we,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  input  logic [9:0] addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RGB,
    S_RGBA,
    S_LUMA2
  } state_t;

  state_t state, state_n;

  logic [3:0][7:0] prev;
  logic [3:0][7:0] cur, cur_n;
  logic [3:0][7:0] pend_px, new_px;
  logic [3:0][7:0] emit_px;
  logic [31:0]     idx_tab [64];
  logic [7:0]      bmem [4][256];

  logic [1:0]  cnt, cnt_n;
  logic [5:0]  lu, lu_n;
  logic [5:0]  run_left, run_n;
  logic        pend;
  logic        load_pend;
  logic        run_load;
  logic [7:0]  ptr;
  logic        wrapped;
  logic        ovr;
  logic        rd_valid;
  logic [7:0]  rd_q;
  logic [7:0]  reg_rd;
  logic [7:0]  status;
  logic [7:0]  dg, dr, db;
  logic [12:0] h_sum;
  logic [5:0]  hash;

  logic reg_wr, ctrl_wr, din_wr;
  logic dec_clr, ptr_clr;
  logic busy, din_ok, emit;
  logic is_rgb, is_rgba, is_idx, is_diff, is_luma;

  assign reg_wr  = cs & we;
  assign ctrl_wr = reg_wr & (addr[2:0] == 3'd0);
  assign din_wr  = reg_wr & (addr[2:0] == 3'd2);
  assign dec_clr = ctrl_wr & data_i[0];
  assign ptr_clr = ctrl_wr & data_i[1];
  assign busy    = pend | (run_left != 6'd0);
  assign din_ok  = din_wr & ~busy;
  assign emit    = busy & ~dec_clr;
  assign emit_px = pend ? pend_px : prev;

  assign is_rgb  = (data_i == 8'hFE);
  assign is_rgba = (data_i == 8'hFF);
  assign is_idx  = (data_i[7:6] == 2'b00);
  assign is_diff = (data_i[7:6] == 2'b01);
  assign is_luma = (data_i[7:6] == 2'b10);

  // Colour hash of the pixel being emitted; mod 64 is the low 6 bits
  always_comb begin
    h_sum = {5'b0, emit_px[0]} * 13'd3
          + {5'b0, emit_px[1]} * 13'd5
          + {5'b0, emit_px[2]} * 13'd7
          + {5'b0, emit_px[3]} * 13'd11;
    hash  = h_sum[5:0];
  end

  // Decoder state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next state and chunk decode for an accepted DATA_IN byte
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cur_n     = cur;
    lu_n      = lu;
    load_pend = 1'b0;
    new_px    = prev;
    run_load  = 1'b0;
    run_n     = 6'd0;
    dg = {2'b00, lu} - 8'd32;
    dr = dg + {4'b0, data_i[7:4]} - 8'd8;
    db = dg + {4'b0, data_i[3:0]} - 8'd8;
    if (din_ok) begin
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            is_rgb: begin
              state_n = S_RGB;
              cnt_n   = 2'd0;
              cur_n   = prev;
            end
            is_rgba: begin
              state_n = S_RGBA;
              cnt_n   = 2'd0;
              cur_n   = prev;
            end
            is_idx: begin
              load_pend = 1'b1;
              new_px    = idx_tab[data_i[5:0]];
            end
            is_diff: begin
              load_pend = 1'b1;
              new_px[0] = prev[0] + {6'b0, data_i[5:4]} - 8'd2;
              new_px[1] = prev[1] + {6'b0, data_i[3:2]} - 8'd2;
              new_px[2] = prev[2] + {6'b0, data_i[1:0]} - 8'd2;
            end
            is_luma: begin
              state_n = S_LUMA2;
              lu_n    = data_i[5:0];
            end
            default: begin
              run_load = 1'b1;
              run_n    = data_i[5:0] + 6'd1;
            end
          endcase
        end
        S_RGB: begin
          cur_n[cnt] = data_i;
          if (cnt == 2'd2) begin
            load_pend = 1'b1;
            new_px    = cur_n;
            state_n   = S_IDLE;
          end else begin
            cnt_n = cnt + 2'd1;
          end
        end
        S_RGBA: begin
          cur_n[cnt] = data_i;
          if (cnt == 2'd3) begin
            load_pend = 1'b1;
            new_px    = cur_n;
            state_n   = S_IDLE;
          end else begin
            cnt_n = cnt + 2'd1;
          end
        end
        S_LUMA2: begin
          load_pend = 1'b1;
          new_px[0] = prev[0] + dr;
          new_px[1] = prev[1] + dg;
          new_px[2] = prev[2] + db;
          state_n   = S_IDLE;
        end
      endcase
    end
    if (dec_clr) state_n = S_IDLE;
  end

  // Decoder datapath: chunk collection, pending pixel, run count, prev
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= 2'd0;
      cur      <= '0;
      lu       <= 6'd0;
      pend     <= 1'b0;
      pend_px  <= '0;
      run_left <= 6'd0;
      prev     <= 32'hFF00_0000;
    end else if (dec_clr) begin
      cnt      <= 2'd0;
      cur      <= '0;
      lu       <= 6'd0;
      pend     <= 1'b0;
      run_left <= 6'd0;
      prev     <= 32'hFF00_0000;
    end else begin
      cnt  <= cnt_n;
      cur  <= cur_n;
      lu   <= lu_n;
      pend <= load_pend;
      if (load_pend) pend_px <= new_px;
      if (run_load)
        run_left <= run_n;
      else if (emit && !pend)
        run_left <= run_left - 6'd1;
      if (emit) prev <= emit_px;
    end
  end

  // Colour index table, updated on every emitted pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) idx_tab[i] <= '0;
    end else if (dec_clr) begin
      for (int i = 0; i < 64; i++) idx_tab[i] <= '0;
    end else if (emit) begin
      idx_tab[hash] <= emit_px;
    end
  end

  // Pixel pointer and sticky wrap flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= 8'd0;
      wrapped <= 1'b0;
    end else if (ptr_clr) begin
      ptr     <= 8'd0;
      wrapped <= 1'b0;
    end else if (emit) begin
      ptr <= ptr + 8'd1;
      if (ptr == 8'hFF) wrapped <= 1'b1;
    end
  end

`ifdef QOI_OVERRUN_EN
  // Sticky flag for DATA_IN bytes lost while busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 ovr <= 1'b0;
    else if (ctrl_wr)         ovr <= 1'b0;
    else if (din_wr && busy)  ovr <= 1'b1;
  end
`else
  assign ovr = 1'b0;
`endif

  // Output buffer lanes; a decoder write lands last and wins a collision
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (mem_cs && we && (addr[1:0] == 2'(l)))
        bmem[l][addr[9:2]] <= data_i;
      if (emit)
        bmem[l][ptr] <= emit_px[l];
    end
  end

  // Registered buffer read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_q     <= 8'd0;
    end else begin
      rd_valid <= mem_cs & ~we;
      if (mem_cs && !we) rd_q <= bmem[addr[1:0]][addr[9:2]];
    end
  end

  assign status = {4'b0, ovr, wrapped, (state == S_IDLE), busy};

  // Combinational register read mux
  always_comb begin
    reg_rd = 8'd0;
    case (addr[2:0])
      3'd1:    reg_rd = status;
      3'd3:    reg_rd = ptr;
      3'd4:    reg_rd = {2'b00, run_left};
      3'd5:    reg_rd = prev[0];
      3'd6:    reg_rd = prev[1];
      3'd7:    reg_rd = prev[2];
      default: reg_rd = 8'd0;
    endcase
  end

  // Read data select: a buffer read from last cycle takes precedence
  always_comb begin
    data_o = 8'd0;
    if (rd_valid)
      data_o = rd_q;
    else if (cs && !we)
      data_o = reg_rd;
  end

endmodule

// File: tb/tb_qoi_decode_accel.sv
// tb_qoi_decode_accel: directed checks of decode, run, wrap and abort.
// Overrun expectations follow QOI_OVERRUN_EN.
module tb_qoi_decode_accel;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       mem_cs;
  logic       we;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic [9:0] addr;

  int total;
  int bad;

  qoi_decode_accel dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .mem_cs (mem_cs),
    .we     (we),
    .data_i (data_i),
    .data_o (data_o),
    .addr   (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = {7'b0, a}; data_i = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = {7'b0, a};
    #2 d = data_o;
    cs = 1'b0;
  endtask

  task automatic wr_mem(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    mem_cs = 1'b1; we = 1'b1; addr = a; data_i = d;
    @(negedge clk);
    mem_cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd_mem(input logic [9:0] a, output logic [7:0] d);
    @(negedge clk);
    mem_cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    mem_cs = 1'b0;
    #1 d = data_o;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    #1;
    total++;
    if (data_o !== 8'h00) begin
      bad++; $display("FAIL reset_data_o got=%h exp=00", data_o);
    end
    rd_reg(3'd1, v); total++;
    if (v !== 8'h02) begin bad++; $display("FAIL reset_status got=%h exp=02", v); end
    rd_reg(3'd3, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL reset_ptr got=%h exp=00", v); end
    rd_reg(3'd4, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL reset_run got=%h exp=00", v); end
    for (int i = 5; i < 8; i++) begin
      rd_reg(3'(i), v); total++;
      if (v !== 8'h00) begin bad++; $display("FAIL reset_prev%0d got=%h exp=00", i, v); end
    end
  endtask

  task automatic test_rgb_index;
    logic [7:0] v;
    logic [7:0] e [8] = '{8'h10, 8'h20, 8'h30, 8'hFF, 8'h10, 8'h20, 8'h30, 8'hFF};
    wr_reg(3'd2, 8'hFE);
    wr_reg(3'd2, 8'h10);
    wr_reg(3'd2, 8'h20);
    wr_reg(3'd2, 8'h30);
    wr_reg(3'd2, 8'h15);
    for (int i = 0; i < 8; i++) begin
      rd_mem(10'(i), v); total++;
      if (v !== e[i]) begin bad++; $display("FAIL rgbidx_byte%0d got=%h exp=%h", i, v, e[i]); end
    end
    rd_reg(3'd3, v); total++;
    if (v !== 8'h02) begin bad++; $display("FAIL rgbidx_ptr got=%h exp=02", v); end
  endtask

  task automatic test_diff_luma;
    logic [7:0] v;
    logic [7:0] e [8] = '{8'h11, 8'h21, 8'h31, 8'hFF, 8'h12, 8'h22, 8'h32, 8'hFF};
    wr_reg(3'd2, 8'h7F);
    wr_reg(3'd2, 8'hA1);
    wr_reg(3'd2, 8'h88);
    for (int i = 0; i < 8; i++) begin
      rd_mem(10'(8 + i), v); total++;
      if (v !== e[i]) begin bad++; $display("FAIL diffluma_byte%0d got=%h exp=%h", 8 + i, v, e[i]); end
    end
    rd_reg(3'd3, v); total++;
    if (v !== 8'h04) begin bad++; $display("FAIL diffluma_ptr got=%h exp=04", v); end
  endtask

  task automatic test_run;
    logic [7:0] v;
    logic [7:0] first_left;
    int busy_cnt;
    logic [7:0] e [4] = '{8'h12, 8'h22, 8'h32, 8'hFF};
    busy_cnt = 0;
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = 10'd2; data_i = 8'hC2;
    @(negedge clk);
    we = 1'b0; addr = 10'd4;
    #1 first_left = data_o;
    addr = 10'd1;
    for (int i = 0; i < 6; i++) begin
      #1 if (data_o[0]) busy_cnt++;
      @(negedge clk);
    end
    cs = 1'b0;
    total++;
    if (first_left !== 8'h03) begin bad++; $display("FAIL run_left_start got=%h exp=03", first_left); end
    total++;
    if (busy_cnt !== 3) begin bad++; $display("FAIL run_busy_cycles got=%0d exp=3", busy_cnt); end
    for (int i = 16; i < 28; i++) begin
      rd_mem(10'(i), v); total++;
      if (v !== e[i % 4]) begin bad++; $display("FAIL run_byte%0d got=%h exp=%h", i, v, e[i % 4]); end
    end
    rd_reg(3'd3, v); total++;
    if (v !== 8'h07) begin bad++; $display("FAIL run_ptr got=%h exp=07", v); end
  endtask

  task automatic test_overrun;
    logic [7:0] v;
    logic exp_ovr;
`ifdef QOI_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = 10'd2; data_i = 8'hFD;
    @(negedge clk);
    data_i = 8'h55;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    repeat (70) @(negedge clk);
    rd_reg(3'd1, v); total++;
    if (v[3] !== exp_ovr) begin bad++; $display("FAIL ovr_flag got=%b exp=%b", v[3], exp_ovr); end
    total++;
    if (v[1:0] !== 2'b10) begin bad++; $display("FAIL ovr_idle got=%b exp=10", v[1:0]); end
    rd_reg(3'd3, v); total++;
    if (v !== 8'h45) begin bad++; $display("FAIL ovr_ptr got=%h exp=45", v); end
    rd_reg(3'd5, v); total++;
    if (v !== 8'h12) begin bad++; $display("FAIL ovr_prev_r got=%h exp=12", v); end
    wr_reg(3'd0, 8'h01);
    rd_reg(3'd1, v); total++;
    if (v[3] !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", v[3]); end
    rd_reg(3'd6, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL ctrl_prev_g got=%h exp=00", v); end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    wr_reg(3'd0, 8'h03);
    rd_reg(3'd3, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL wrap_ptr_clr got=%h exp=00", v); end
    for (int i = 0; i < 4; i++) begin
      wr_reg(3'd2, 8'hFD);
      repeat (64) @(negedge clk);
    end
    wr_reg(3'd2, 8'hC7);
    repeat (12) @(negedge clk);
    rd_reg(3'd3, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL wrap_ptr got=%h exp=00", v); end
    rd_reg(3'd1, v); total++;
    if (v[2] !== 1'b1) begin bad++; $display("FAIL wrap_flag got=%b exp=1", v[2]); end
    rd_mem(10'd1023, v); total++;
    if (v !== 8'hFF) begin bad++; $display("FAIL wrap_last_a got=%h exp=FF", v); end
    rd_mem(10'd1020, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL wrap_last_r got=%h exp=00", v); end
  endtask

  task automatic test_abort;
    logic [7:0] v;
    wr_mem(10'd160, 8'hAA);
    wr_reg(3'd2, 8'hFD);
    repeat (5) @(negedge clk);
    rd_reg(3'd4, v); total++;
    if (v == 8'h00) begin bad++; $display("FAIL abort_midrun got=%h exp=nonzero", v); end
    wr_reg(3'd0, 8'h03);
    repeat (70) @(negedge clk);
    rd_reg(3'd3, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL abort_ptr got=%h exp=00", v); end
    rd_reg(3'd4, v); total++;
    if (v !== 8'h00) begin bad++; $display("FAIL abort_run got=%h exp=00", v); end
    rd_reg(3'd1, v); total++;
    if (v[1:0] !== 2'b10) begin bad++; $display("FAIL abort_status got=%b exp=10", v[1:0]); end
    rd_mem(10'd160, v); total++;
    if (v !== 8'hAA) begin bad++; $display("FAIL abort_nowrite got=%h exp=AA", v); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    cs = 1'b0;
    mem_cs = 1'b0;
    we = 1'b0;
    data_i = 8'h00;
    addr = 10'd0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    test_reset;
    test_rgb_index;
    test_diff_luma;
    test_run;
    test_overrun;
    test_wrap;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
